// File: rtl/depth_test.sv
// Depth-test stage: read-compare-write against an on-chip depth buffer, emitting
// frame-buffer writes only for closer pixels, plus the per-frame depth clear.
module depth_test #(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 180,
  parameter int DEPTH_BITS = 8
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic [10:0]           hcount_in,
  input  logic [9:0]            vcount_in,
  input  logic [DEPTH_BITS-1:0] depth_in,
  input  logic [15:0]           color_in,
  input  logic                  pixel_valid_in,
  input  logic                  frame_start_in,
  output logic                  ready_out,
  output logic [16:0]           fb_addr_out,
  output logic [15:0]           fb_color_out,
  output logic                  fb_write_out,
  output logic                  clear_done_out
);
  // state | meaning
  // IDLE  | accepting pixels
  // DRAIN | waiting for in-flight pixels to retire before clearing
  // CLEAR | writing far depth to every location, one per cycle
  localparam int                    NPIX = WIDTH * HEIGHT;
  localparam int                    IW   = $clog2(NPIX);
  localparam logic [16:0]           LAST = 17'(NPIX - 1);
  localparam logic [DEPTH_BITS-1:0] FAR  = '1;

  typedef enum logic [1:0] {IDLE, DRAIN, CLEAR} state_t;

  state_t                r_state;
  logic [16:0]           r_clr_addr;
  logic [DEPTH_BITS-1:0] r_mem [0:NPIX-1];

  logic                  r_s0_v, r_s1_v, r_s2_v;
  logic [16:0]           r_s0_addr, r_s1_addr, r_s2_addr;
  logic [DEPTH_BITS-1:0] r_s0_depth, r_s1_depth, r_s2_depth;
  logic [15:0]           r_s0_color, r_s1_color, r_s2_color;
  logic [DEPTH_BITS-1:0] r_rd1, r_rd2;

  logic [DEPTH_BITS-1:0] r_w1_depth;
  logic                  r_w2_v;
  logic [16:0]           r_w2_addr;
  logic [DEPTH_BITS-1:0] r_w2_depth;

  logic                  w_in_range, w_accept, w_pass;
  logic [16:0]           w_addr_in;
  logic [DEPTH_BITS-1:0] w_stored;

  assign w_in_range = (hcount_in < 11'(WIDTH)) && (vcount_in < 10'(HEIGHT));
  assign w_accept   = pixel_valid_in && ready_out && w_in_range;
  assign w_addr_in  = 17'(vcount_in) * 17'(WIDTH) + 17'(hcount_in);

  // The last two passes are not yet visible in the BRAM read data, newest wins.
  assign w_stored = (fb_write_out && (fb_addr_out == r_s2_addr)) ? r_w1_depth :
                    (r_w2_v && (r_w2_addr == r_s2_addr))        ? r_w2_depth : r_rd2;
  assign w_pass   = r_s2_v && (r_s2_depth < w_stored);

  always_ff @(posedge clk_in) begin
    if (r_state == CLEAR) begin
      r_mem[r_clr_addr[IW-1:0]] <= FAR;
    end else if (w_pass) begin
      r_mem[r_s2_addr[IW-1:0]] <= r_s2_depth;
    end
    r_rd1 <= r_mem[r_s0_addr[IW-1:0]];
    r_rd2 <= r_rd1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_s0_v       <= 1'b0;
      r_s1_v       <= 1'b0;
      r_s2_v       <= 1'b0;
      r_s0_addr    <= '0;
      r_s1_addr    <= '0;
      r_s2_addr    <= '0;
      r_s0_depth   <= '0;
      r_s1_depth   <= '0;
      r_s2_depth   <= '0;
      r_s0_color   <= '0;
      r_s1_color   <= '0;
      r_s2_color   <= '0;
      fb_write_out <= 1'b0;
      fb_addr_out  <= '0;
      fb_color_out <= '0;
      r_w1_depth   <= '0;
      r_w2_v       <= 1'b0;
      r_w2_addr    <= '0;
      r_w2_depth   <= '0;
    end else begin
      r_s0_v <= w_accept;
      if (w_accept) begin
        r_s0_addr  <= w_addr_in;
        r_s0_depth <= depth_in;
        r_s0_color <= color_in;
      end
      r_s1_v     <= r_s0_v;
      r_s1_addr  <= r_s0_addr;
      r_s1_depth <= r_s0_depth;
      r_s1_color <= r_s0_color;
      r_s2_v     <= r_s1_v;
      r_s2_addr  <= r_s1_addr;
      r_s2_depth <= r_s1_depth;
      r_s2_color <= r_s1_color;

      fb_write_out <= w_pass;
      if (w_pass) begin
        fb_addr_out  <= r_s2_addr;
        fb_color_out <= r_s2_color;
        r_w1_depth   <= r_s2_depth;
      end
      r_w2_v     <= fb_write_out;
      r_w2_addr  <= fb_addr_out;
      r_w2_depth <= r_w1_depth;
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_state        <= CLEAR;
      r_clr_addr     <= '0;
      ready_out      <= 1'b0;
      clear_done_out <= 1'b0;
    end else begin
      clear_done_out <= 1'b0;
      case (r_state)
        IDLE: begin
          if (frame_start_in) begin
            r_state   <= DRAIN;
            ready_out <= 1'b0;
          end else begin
            ready_out <= 1'b1;
          end
        end
        DRAIN: begin
          if (!(r_s0_v || r_s1_v || r_s2_v)) begin
            r_state    <= CLEAR;
            r_clr_addr <= '0;
          end
        end
        CLEAR: begin
          if (r_clr_addr == LAST) begin
            clear_done_out <= 1'b1;
            r_state        <= IDLE;
          end else begin
            r_clr_addr <= r_clr_addr + 17'd1;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_depth_test.sv
// Bench for depth_test at a reduced resolution so several full clears fit in one run.
module tb_depth_test;
  localparam int W  = 40;
  localparam int H  = 24;
  localparam int NP = W * H;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic [7:0]  depth_in;
  logic [15:0] color_in;
  logic        pixel_valid_in;
  logic        frame_start_in;
  logic        ready_out;
  logic [16:0] fb_addr_out;
  logic [15:0] fb_color_out;
  logic        fb_write_out;
  logic        clear_done_out;

  always #5 clk_in = ~clk_in;

  depth_test #(.WIDTH(W), .HEIGHT(H), .DEPTH_BITS(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .hcount_in(hcount_in), .vcount_in(vcount_in),
    .depth_in(depth_in), .color_in(color_in),
    .pixel_valid_in(pixel_valid_in), .frame_start_in(frame_start_in),
    .ready_out(ready_out), .fb_addr_out(fb_addr_out),
    .fb_color_out(fb_color_out), .fb_write_out(fb_write_out),
    .clear_done_out(clear_done_out)
  );

  typedef struct {bit w; int a; int c;} exp_t;
  typedef struct {bit v; int h; int y; int d; int c; bit ew; int ea; int ec;} vec_t;

  exp_t q[$];
  int   ref_mem [NP];
  bit   model_ready;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: drive a pixel, predict its outcome sequentially, check the
  // output belonging to the pixel driven three clocks earlier.
  task automatic cyc(input bit v, input int h, input int y, input int d, input int c,
                     input bit fs, input bit ovr, input exp_t tx);
    exp_t e;
    int   a;
    pixel_valid_in = v;
    hcount_in      = 11'(h);
    vcount_in      = 10'(y);
    depth_in       = 8'(d);
    color_in       = 16'(c);
    frame_start_in = fs;
    e = '{w: 1'b0, a: 0, c: 0};
    if (v && model_ready && h < W && y < H) begin
      a = y * W + h;
      if (d < ref_mem[a]) begin
        ref_mem[a] = d;
        e = '{w: 1'b1, a: a, c: c};
      end
    end
    if (ovr) e = tx;
    if (fs && model_ready) model_ready = 1'b0;
    q.push_back(e);
    @(posedge clk_in);
    #1;
    if (q.size() > 3) begin
      e = q.pop_front();
      chk("fb_write", int'(fb_write_out), int'(e.w));
      if (e.w) begin
        chk("fb_addr", int'(fb_addr_out), e.a);
        chk("fb_color", int'(fb_color_out), e.c);
      end
    end
    chk("ready", int'(ready_out), int'(model_ready));
  endtask

  task automatic idle();
    exp_t z;
    z = '{w: 1'b0, a: 0, c: 0};
    cyc(1'b0, 0, 0, 0, 0, 1'b0, 1'b0, z);
  endtask

  task automatic pix(input int h, input int y, input int d, input int c, input bit fs);
    exp_t z;
    z = '{w: 1'b0, a: 0, c: 0};
    cyc(1'b1, h, y, d, c, fs, 1'b0, z);
  endtask

  // Runs idle clocks until clear_done_out, checks the length, then the
  // one-cycle pulse and ready on the following clock.
  task automatic wait_clear(input int exp_n, input string name);
    int n;
    n = 0;
    for (int i = 0; i < exp_n + 20; i++) begin
      idle();
      n++;
      if (clear_done_out) break;
    end
    chk(name, n, exp_n);
    for (int i = 0; i < NP; i++) ref_mem[i] = 255;
    model_ready = 1'b1;
    idle();
    chk("clear_done_pulse_len", int'(clear_done_out), 0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_ready", int'(ready_out), 0);
    chk("rst_fb_write", int'(fb_write_out), 0);
    chk("rst_fb_addr", int'(fb_addr_out), 0);
    chk("rst_fb_color", int'(fb_color_out), 0);
    chk("rst_clear_done", int'(clear_done_out), 0);
  endtask

  vec_t tab[9];

  initial begin
    tab[0] = '{v: 1, h: 10, y: 5,  d: 40, c: 'hF800, ew: 1, ea: 210, ec: 'hF800};
    tab[1] = '{v: 1, h: 3,  y: 2,  d: 40, c: 'h0001, ew: 1, ea: 83,  ec: 'h0001};
    tab[2] = '{v: 1, h: 3,  y: 2,  d: 30, c: 'h0002, ew: 1, ea: 83,  ec: 'h0002};
    tab[3] = '{v: 1, h: 3,  y: 2,  d: 35, c: 'h0003, ew: 0, ea: 0,   ec: 0};
    tab[4] = '{v: 1, h: 7,  y: 7,  d: 30, c: 'h07E0, ew: 1, ea: 287, ec: 'h07E0};
    tab[5] = '{v: 1, h: 7,  y: 7,  d: 30, c: 'h001F, ew: 0, ea: 0,   ec: 0};
    tab[6] = '{v: 1, h: 40, y: 0,  d: 0,  c: 'hAAAA, ew: 0, ea: 0,   ec: 0};
    tab[7] = '{v: 1, h: 0,  y: 24, d: 0,  c: 'h5555, ew: 0, ea: 0,   ec: 0};
    tab[8] = '{v: 1, h: 39, y: 23, d: 0,  c: 'h1234, ew: 1, ea: 959, ec: 'h1234};

    rst_in = 1'b0;
    pixel_valid_in = 1'b0;
    frame_start_in = 1'b0;
    hcount_in = '0;
    vcount_in = '0;
    depth_in = '0;
    color_in = '0;
    model_ready = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    chk_reset_outputs();
    rst_in = 1'b1;
    wait_clear(NP, "init_clear_len");

    for (int i = 0; i < 9; i++) begin
      exp_t tx;
      tx = '{w: tab[i].ew, a: tab[i].ea, c: tab[i].ec};
      cyc(tab[i].v, tab[i].h, tab[i].y, tab[i].d, tab[i].c, 1'b0, 1'b1, tx);
    end
    repeat (3) idle();

    // Pixel accepted together with frame_start, then three dropped pixels.
    pix(20, 10, 100, 'h07E0, 1'b1);
    repeat (3) pix(1, 1, 0, 'hFFFF, 1'b0);
    wait_clear(NP + 1, "fs_clear_len");

    for (int i = 0; i < 1500; i++) begin
      int h, y;
      if ($urandom_range(0, 1) == 0) begin
        h = $urandom_range(36, 39);
        y = $urandom_range(22, 23);
      end else begin
        h = $urandom_range(0, W + 1);
        y = $urandom_range(0, H + 1);
      end
      if ($urandom_range(0, 3) != 0)
        pix(h, y, $urandom_range(0, 255), $urandom_range(0, 65535), 1'b0);
      else
        idle();
    end
    pix(39, 23, 0, 'h4321, 1'b0);
    pix(39, 23, 0, 'h4321, 1'b0);
    repeat (3) idle();

    // Abort a clear part-way with reset; the restart must cover every address.
    pix(0, 0, 255, 0, 1'b1);
    repeat (502) idle();
    rst_in = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    model_ready = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b1;
    wait_clear(NP, "rst_clear_len");
    pix(39, 23, 254, 'hBEEF, 1'b0);
    pix(0, 0, 254, 'hCAFE, 1'b0);
    repeat (3) idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/depth_test.md
Name: depth_test

Overview:
- Sits directly downstream of the rasterizer.
- Consumes the per-pixel stream (hcount, vcount, depth, colour) the rasterizer produces.
- Performs a read-compare-write against an internal depth buffer and emits frame-buffer write commands only for pixels that are closer than what is already stored.
- Owns the per-frame depth-buffer clear and stalls upstream while clearing.

Parameters:
- WIDTH, 320, horizontal resolution in pixels.
- HEIGHT, 180, vertical resolution in pixels.
- DEPTH_BITS, 8, stored depth width; all-ones means "far / empty".

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  asynchronous, active-low reset.
- hcount_in  input  11  pixel x.
- vcount_in  input  10  pixel y.
- depth_in  input  DEPTH_BITS  pixel depth; smaller is closer.
- color_in  input  16  pixel colour (RGB565).
- pixel_valid_in  input  1  pixel present this cycle.
- frame_start_in  input  1  one-cycle pulse requesting a depth-buffer clear.
- ready_out  output  1  block accepts pixels this cycle.
- fb_addr_out  output  17  frame-buffer address, vcount*WIDTH+hcount.
- fb_color_out  output  16  colour to write.
- fb_write_out  output  1  frame-buffer write strobe.
- clear_done_out  output  1  one-cycle pulse when a clear finishes.

Behaviour:
- Reset (rst_in low, asynchronous): state=CLEAR, clear address=0, ready_out=0, fb_write_out=0, fb_addr_out=0, fb_color_out=0, clear_done_out=0, pipeline valid bits cleared. Reset asserted mid-operation aborts everything; the clear restarts from address 0 after release.
- Handshake: a pixel is accepted on a rising edge where pixel_valid_in && ready_out. pixel_valid_in while ready_out=0 is ignored (dropped, not held).
- Range check at accept: hcount_in>=WIDTH or vcount_in>=HEIGHT is discarded; it enters no pipeline stage and produces no write.
- Pipeline, one pixel per cycle, no back-pressure once accepted:
  - S0 (accept cycle t): register address=vcount*WIDTH+hcount (17 bits), depth, colour.
  - S1, S2: depth BRAM read, 2-cycle latency.
  - S3: compare and write.
- Compare rule:
  - Pass iff new depth < stored depth (strict; ties fail).
  - On pass: write new depth to the BRAM and assert fb_write_out with fb_addr_out/fb_color_out, registered, visible in cycle t+3.
  - On fail: fb_write_out=0.
- Forwarding:
  - The stored depth used in S3 is the depth written by either of the previous two S3 passes to the same address, most recent taking priority.
  - If no such pass exists, the BRAM read data is used.
  - Back-to-back pixels to one address must behave exactly as if processed sequentially.
- FSM states: IDLE, DRAIN, CLEAR.
  - IDLE: ready_out=1. On frame_start_in, go to DRAIN; ready_out=0 from the next cycle. A pixel accepted in the same cycle as frame_start_in is processed normally.
  - DRAIN: wait until S0–S3 are empty (at most 4 cycles), then go to CLEAR with address=0.
  - CLEAR: write all-ones depth to one address per cycle, 0..WIDTH*HEIGHT-1. After the last address, pulse clear_done_out for one cycle and go to IDLE. fb_write_out stays 0 throughout; the frame buffer is not cleared.
  - frame_start_in in DRAIN or CLEAR is ignored.
- Clear duration: WIDTH*HEIGHT cycles (57600 at defaults). Reset-to-first-ready latency is 57600 cycles plus 1.
- Arithmetic: address multiply is unsigned and sized for WIDTH*HEIGHT-1 < 2^17. Depth compare is unsigned.

Test Plan:
- Reset release -> ready_out=0 for 57600 cycles; clear_done_out pulses once; ready_out=1 on the next cycle; fb_write_out never asserted.
- After clear, pixel (10,5,depth=40,color=0xF800) -> cycle t+3: fb_write_out=1, fb_addr_out=1610, fb_color_out=0xF800.
- Same address, three consecutive cycles, depths 40, 30, 35 on a cleared buffer -> writes for 40 and 30, none for 35 (forwarding exercised). Depth 30 then 30 again -> second write suppressed.
- Pixels (320,0) and (0,180) with valid -> no write; the following valid pixel (319,179,depth=0) -> write with addr 57599.
- frame_start_in in the same cycle as an accepted pixel followed by 3 more valids -> the first pixel is written at t+3; the next 3 are ignored (ready_out=0); clear begins after drain and clear_done_out pulses 57600 cycles later.
- rst_in pulsed low mid-CLEAR at address 1000 -> outputs return to reset values immediately; after release the clear restarts at 0 and takes the full 57600 cycles.
